nubus_bus_steer: RTL
====================

Name: nubus_bus_steer

Overview:
Clocked successor to the NuBus CPLD glue. It sequences level-shifter direction and output-enable with guaranteed dead (all-Z) turnaround cycles, and runs a registered NuBus arbitration/request handshake for the FPGA master. ID/arbitration width and turnaround/settle timing are parametrised, and it keeps a saturating lost-arbitration counter. It sits between the 5V-side pin buffers and the FPGA master/slave engines, on the 3.3V side.

Parameters:
ARB_W, 4, number of ID/arbitration lines
TURN_CYCLES, 1, dead cycles with all drivers Z on any direction change (legal range 1..15)
ARB_SETTLE, 2, consecutive idle cycles (start_n_in high) before arbitration is resolved (legal range 1..15)
CNT_W, 8, width of the lost-arbitration counter

Ports:
clk  in  1  NuBus-derived clock; all state updates on its rising edge
reset_n  in  1  asynchronous, active-low reset
id_n  in  ARB_W  card slot ID, active-low, static
arb_n_in  in  ARB_W  sampled NuBus ARB lines, active-low
arb_o_n  out  ARB_W  open-collector ARB drive; 0 = pull low
rqst_o_n  out  1  NuBus RQST drive, active-low
start_n_in  in  1  sampled NuBus START
mst_req  in  1  FPGA master wants the bus (level)
mst_done  in  1  one-cycle pulse: master transaction finished
slv_resp  in  1  FPGA slave wants to drive ACK/TM lines
grant  out  1  bus owned; master may drive
master_dir  out  1  1 = START/RQST buffers point to NuBus
slv_dir  out  1  registered ACK/TM direction (drive-to-NuBus phase)
nubus_oe  out  1  1 = all 5V drivers disabled (Z)
busy  out  1  state != IDLE
lost_cnt  out  CNT_W  saturating count of lost arbitrations

Behaviour:
- Reset (asynchronous): state=IDLE; grant=0, master_dir=0, slv_dir=0, nubus_oe=1, rqst_o_n=1, arb_o_n=all 1, lost_cnt=0, busy=0. The first cycle after reset release is a turnaround: nubus_oe stays 1 for TURN_CYCLES cycles, then drops to 0.
- arb_o_n is combinational from registered arb_en: bit i = 0 iff arb_en && id_n[i]==0 && for every j>i, NOT (arb_n_in[j]==0 && id_n[j]==1). With arb_en=0, all bits are 1.
- States: IDLE, SLV_TURN, ARB, M_TURN, MASTER, REL_TURN.
- IDLE: nubus_oe=0, master_dir=0.
  - If slv_resp != slv_dir: go to SLV_TURN. This has priority over mst_req when both occur in the same cycle.
  - Otherwise, if mst_req: go to ARB.
- SLV_TURN: nubus_oe=1 for TURN_CYCLES cycles. On exit, slv_dir<=slv_resp, nubus_oe<=0, back to IDLE. A slv_resp change during the turnaround is handled by a new turnaround afterwards.
- ARB: rqst_o_n=0, arb_en=1; settle counter counts consecutive start_n_in==1 cycles and clears on start_n_in==0.
  - When count reaches ARB_SETTLE: if arb_n_in==id_n, go to M_TURN.
  - Otherwise lost_cnt++ (saturates at all-ones), counter clears, and the block stays in ARB.
  - mst_req deasserted in ARB: rqst_o_n=1, arb_en=0 next cycle, back to IDLE, no count increment.
- M_TURN: arb_en=0, rqst_o_n=0, nubus_oe=1 for TURN_CYCLES. On exit, master_dir=1, nubus_oe=0, grant=1, go to MASTER.
- MASTER: grant=1, rqst_o_n=1 from the first MASTER cycle. On mst_done: grant=0 next cycle, go to REL_TURN.
- REL_TURN: nubus_oe=1, master_dir=0 for TURN_CYCLES, then IDLE.
- Invariant: master_dir and slv_dir change only in cycles where nubus_oe=1.
- Latency: mst_req to grant = 1 (IDLE→ARB) + ARB_SETTLE + TURN_CYCLES cycles minimum.
- mst_done outside MASTER is ignored. mst_req held high through REL_TURN re-arbitrates from IDLE.
- Reset asserted mid-operation: immediate return to reset values, no turnaround requirement.

Test Plan:
- Reset release, TURN_CYCLES=1 → nubus_oe=1 for exactly 1 cycle, then 0; all other outputs at reset values; lost_cnt=0.
- id_n=4'b1100, arb_n_in follows arb_o_n (no competitor), mst_req=1, start_n_in=1 → arb_o_n=4'b1100; grant rises 4 cycles after mst_req (ARB_SETTLE=2); nubus_oe=1 for the single cycle before master_dir=1.
- Competitor: arb_n_in=4'b0100 vs id_n=4'b1100 → arb_o_n bits 1..0 released (arb_o_n=4'b1111), no grant, lost_cnt increments once per settle window. With CNT_W=2, the counter stops at 3.
- Grant then mst_done pulse → grant=0 next cycle; nubus_oe=1 and master_dir=0 for TURN_CYCLES; busy=0 after that.
- mst_req and slv_resp rise in the same IDLE cycle → SLV_TURN first, slv_dir=1 after the turnaround, then ARB. master_dir and slv_dir never change while nubus_oe=0.
- reset_n pulsed low in MASTER → grant, master_dir and rqst_o_n go inactive and nubus_oe=1 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/nubus_bus_steer.sv
// NuBus 5V buffer steering and registered arbitration/request handshake for the FPGA master.
// Every buffer direction change is bracketed by TURN_CYCLES dead cycles with all drivers Z.
module nubus_bus_steer #(
    parameter int ARB_W       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int ARB_SETTLE  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ARB_W-1:0] id_n,
    input  logic [ARB_W-1:0] arb_n_in,
    output logic [ARB_W-1:0] arb_o_n,
    output logic             rqst_o_n,
    input  logic             start_n_in,
    input  logic             mst_req,
    input  logic             mst_done,
    input  logic             slv_resp,
    output logic             grant,
    output logic             master_dir,
    output logic             slv_dir,
    output logic             nubus_oe,
    output logic             busy,
    output logic [CNT_W-1:0] lost_cnt
);
    typedef enum logic [2:0] {IDLE, SLV_TURN, ARB, M_TURN, MASTER, REL_TURN} state_t;

    localparam logic [3:0]       TURN_LAST   = 4'(TURN_CYCLES - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(ARB_SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [3:0]       scnt_q, scnt_d;
    logic             init_q, init_d;
    logic             oe_q, oe_d;
    logic             mdir_q, mdir_d;
    logic             sdir_q, sdir_d;
    logic             grant_q, grant_d;
    logic             rqst_q, rqst_d;
    logic             arb_en_q, arb_en_d;
    logic [CNT_W-1:0] lost_q, lost_d;

    logic turn_done;
    assign turn_done = (tcnt_q == TURN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            scnt_q   <= '0;
            init_q   <= 1'b1;
            oe_q     <= 1'b1;
            mdir_q   <= 1'b0;
            sdir_q   <= 1'b0;
            grant_q  <= 1'b0;
            rqst_q   <= 1'b1;
            arb_en_q <= 1'b0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            scnt_q   <= scnt_d;
            init_q   <= init_d;
            oe_q     <= oe_d;
            mdir_q   <= mdir_d;
            sdir_q   <= sdir_d;
            grant_q  <= grant_d;
            rqst_q   <= rqst_d;
            arb_en_q <= arb_en_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        scnt_d   = scnt_q;
        init_d   = init_q;
        oe_d     = oe_q;
        mdir_d   = mdir_q;
        sdir_d   = sdir_q;
        grant_d  = grant_q;
        rqst_d   = rqst_q;
        arb_en_d = arb_en_q;
        lost_d   = lost_q;
        case (state_q)
            IDLE: begin
                // Out of reset the buffers stay Z for one turnaround before IDLE acts.
                if (init_q) begin
                    if (turn_done) begin
                        init_d = 1'b0;
                        oe_d   = 1'b0;
                        tcnt_d = '0;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end else if (slv_resp != sdir_q) begin
                    state_d = SLV_TURN;
                    oe_d    = 1'b1;
                    tcnt_d  = '0;
                end else if (mst_req) begin
                    state_d  = ARB;
                    rqst_d   = 1'b0;
                    arb_en_d = 1'b1;
                    scnt_d   = '0;
                end
            end
            SLV_TURN: begin
                if (turn_done) begin
                    state_d = IDLE;
                    sdir_d  = slv_resp;
                    oe_d    = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            ARB: begin
                if (!mst_req) begin
                    state_d  = IDLE;
                    rqst_d   = 1'b1;
                    arb_en_d = 1'b0;
                end else if (start_n_in == 1'b0) begin
                    scnt_d = '0;
                end else if (scnt_q == SETTLE_LAST) begin
                    scnt_d = '0;
                    if (arb_n_in == id_n) begin
                        state_d  = M_TURN;
                        arb_en_d = 1'b0;
                        oe_d     = 1'b1;
                        tcnt_d   = '0;
                    end else if (lost_q != '1) begin
                        lost_d = lost_q + CNT_ONE;
                    end
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            M_TURN: begin
                if (turn_done) begin
                    state_d = MASTER;
                    mdir_d  = 1'b1;
                    oe_d    = 1'b0;
                    grant_d = 1'b1;
                    rqst_d  = 1'b1;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            MASTER: begin
                if (mst_done) begin
                    state_d = REL_TURN;
                    grant_d = 1'b0;
                    oe_d    = 1'b1;
                    mdir_d  = 1'b0;
                    tcnt_d  = '0;
                end
            end
            REL_TURN: begin
                if (turn_done) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drop our low ID bits once a higher line is pulled by a card whose ID has that bit set.
    always_comb begin
        logic beaten;
        beaten  = 1'b0;
        arb_o_n = '1;
        for (int i = 0; i < ARB_W; i++) begin
            beaten = 1'b0;
            for (int j = i + 1; j < ARB_W; j++)
                beaten = beaten | (~arb_n_in[j] & id_n[j]);
            arb_o_n[i] = ~(arb_en_q & ~id_n[i] & ~beaten);
        end
    end

    assign rqst_o_n   = rqst_q;
    assign grant      = grant_q;
    assign master_dir = mdir_q;
    assign slv_dir    = sdir_q;
    assign nubus_oe   = oe_q;
    assign busy       = (state_q != IDLE);
    assign lost_cnt   = lost_q;

endmodule
